cs_scheduler: RTL

Two-requester chip-select scheduler that shares one peripheral select slot between two work sources. It grants the slot to one requester at a time with round-robin fairness. It drives a fixed-length active-high chip-select window for the granted requester, then enforces a deassert gap before the next grant. It sits upstream of the chip-select generation stage, converting level work requests into timed, mutually exclusive cs1/cs2 windows.

---
 rtl/cs_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cs_scheduler.sv
// Round-robin scheduler sharing one chip-select slot between two requesters.
// Each grant opens a HOLD-cycle cs window followed by a GAP-cycle dead time.
module cs_scheduler #(
  parameter int HOLD  = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  output logic cs1,
  output logic cs2,
  output logic gnt1,
  output logic gnt2,
  output logic done1,
  output logic done2,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP_S  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit GAP_ZERO = (GAP == 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             cs1_q, cs1_d, cs2_q, cs2_d;
  logic             gnt1_q, gnt1_d, gnt2_q, gnt2_d;
  logic             done1_q, done1_d;
  logic             done2_q, done2_d;
  logic             busy_q, busy_d;
  logic             pick2;

  // last_q=1 means requester 2 was served last
  assign pick2 = req2 & (~req1 | ~last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cs1_d   = 1'b0;
    cs2_d   = 1'b0;
    gnt1_d  = 1'b0;
    gnt2_d  = 1'b0;
    done1_d = 1'b0;
    done2_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req1 | req2) begin
          state_d = ACTIVE;
          cnt_d   = HOLD_LD;
          owner_d = pick2;
          last_d  = pick2;
          cs1_d   = ~pick2;
          cs2_d   = pick2;
          gnt1_d  = ~pick2;
          gnt2_d  = pick2;
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          done1_d = ~owner_q;
          done2_d = owner_q;
          cnt_d   = GAP_LD;
          state_d = GAP_ZERO ? IDLE : GAP_S;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          cs1_d = ~owner_q;
          cs2_d = owner_q;
        end
      end
      GAP_S: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cs1_q   <= 1'b0;
      cs2_q   <= 1'b0;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cs1_q   <= cs1_d;
      cs2_q   <= cs2_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
      busy_q  <= busy_d;
    end
  end

  assign cs1   = cs1_q;
  assign cs2   = cs2_q;
  assign gnt1  = gnt1_q;
  assign gnt2  = gnt2_q;
  assign done1 = done1_q;
  assign done2 = done2_q;
  assign busy  = busy_q;

endmodule
